// File: rtl/sram_arb_pkg.sv
// Shared types for the two-host SRAM arbiter.
package sram_arb_pkg;

  localparam int unsigned NumHosts = 2;

  typedef enum logic {
    Host0 = 1'b0,
    Host1 = 1'b1
  } host_id_e;

  // One read-tracking pipeline stage: whether a read is in flight and who issued it.
  typedef struct packed {
    logic     valid;
    host_id_e owner;
  } rd_tag_t;

  function automatic host_id_e other_host(input host_id_e h);
    return (h == Host0) ? Host1 : Host0;
  endfunction

endpackage

// File: rtl/sram_arb_rdtrack.sv
// Read-tag shift register: delays each accepted read's owner by ReadLatency
// cycles and steers the RAM read data to that host only.
module sram_arb_rdtrack
  import sram_arb_pkg::*;
#(
  parameter int unsigned ReadLatency = 1,
  parameter int unsigned SramDw      = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  rd_tag_t           tag_i,
  input  logic [SramDw-1:0] ram_rdata_i,
  output logic              h0_rvalid_o,
  output logic              h1_rvalid_o,
  output logic [SramDw-1:0] h0_rdata_o,
  output logic [SramDw-1:0] h1_rdata_o
);

  rd_tag_t [ReadLatency-1:0] pipe_q, pipe_d;
  rd_tag_t                   head;

  // Next pipeline contents: new tag enters stage 0, every stage advances each cycle.
  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = tag_i;
    for (int unsigned i = 1; i < ReadLatency; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Pipeline register; reset discards all in-flight reads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  // Decode the oldest stage into per-host valid and gated read data.
  always_comb begin
    head        = pipe_q[ReadLatency-1];
    h0_rvalid_o = head.valid && (head.owner == Host0);
    h1_rvalid_o = head.valid && (head.owner == Host1);
    h0_rdata_o  = h0_rvalid_o ? ram_rdata_i : '0;
    h1_rdata_o  = h1_rvalid_o ? ram_rdata_i : '0;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between two SRAM-style
// hosts; generates rvalid for reads and routes read data to the issuer.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned SramAw      = 11,
  parameter int unsigned SramDw      = 32,
  parameter int unsigned ReadLatency = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              h0_req_i,
  output logic              h0_gnt_o,
  input  logic              h0_we_i,
  input  logic [SramAw-1:0] h0_addr_i,
  input  logic [SramDw-1:0] h0_wdata_i,
  input  logic [SramDw-1:0] h0_wmask_i,
  output logic              h0_rvalid_o,
  output logic [SramDw-1:0] h0_rdata_o,
  input  logic              h1_req_i,
  output logic              h1_gnt_o,
  input  logic              h1_we_i,
  input  logic [SramAw-1:0] h1_addr_i,
  input  logic [SramDw-1:0] h1_wdata_i,
  input  logic [SramDw-1:0] h1_wmask_i,
  output logic              h1_rvalid_o,
  output logic [SramDw-1:0] h1_rdata_o,
  output logic              ram_req_o,
  output logic              ram_we_o,
  output logic [SramAw-1:0] ram_addr_o,
  output logic [SramDw-1:0] ram_wdata_o,
  output logic [SramDw-1:0] ram_wmask_o,
  input  logic [SramDw-1:0] ram_rdata_i
);

  host_id_e last_q, last_d;
  host_id_e winner;
  logic     accept;
  rd_tag_t  rd_tag;

  // Any request is always granted to exactly one host, so acceptance equals ram_req.
  assign accept    = h0_req_i | h1_req_i;
  assign ram_req_o = accept;

  // Winner selection: a lone requester wins; on conflict the host not granted last wins.
  always_comb begin
    winner = Host0;
    if (h0_req_i && h1_req_i) begin
      winner = other_host(last_q);
    end else if (h1_req_i) begin
      winner = Host1;
    end
  end

  assign h0_gnt_o = accept && (winner == Host0);
  assign h1_gnt_o = accept && (winner == Host1);

  // RAM payload mux from the granted host; all fields zero when idle.
  always_comb begin
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_wmask_o = '0;
    if (h0_gnt_o) begin
      ram_we_o    = h0_we_i;
      ram_addr_o  = h0_addr_i;
      ram_wdata_o = h0_wdata_i;
      ram_wmask_o = h0_wmask_i;
    end else if (h1_gnt_o) begin
      ram_we_o    = h1_we_i;
      ram_addr_o  = h1_addr_i;
      ram_wdata_o = h1_wdata_i;
      ram_wmask_o = h1_wmask_i;
    end
  end

  // Last-grant pointer moves only on an accepted transfer.
  always_comb begin
    last_d = last_q;
    if (accept) begin
      last_d = winner;
    end
  end

  // Pointer register; reset to host 1 so host 0 wins the first conflict.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= Host1;
    end else begin
      last_q <= last_d;
    end
  end

  // Tag entering the read tracker: only accepted reads are marked valid.
  always_comb begin
    rd_tag       = '0;
    rd_tag.valid = accept && !ram_we_o;
    rd_tag.owner = winner;
  end

  sram_arb_rdtrack #(
    .ReadLatency(ReadLatency),
    .SramDw     (SramDw)
  ) u_rdtrack (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .tag_i      (rd_tag),
    .ram_rdata_i(ram_rdata_i),
    .h0_rvalid_o(h0_rvalid_o),
    .h1_rvalid_o(h1_rvalid_o),
    .h0_rdata_o (h0_rdata_o),
    .h1_rdata_o (h1_rdata_o)
  );

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: one instance with ReadLatency=1 and one with 3, both
// driven by the same hosts, each with its own RAM model, checked every cycle
// against a transaction-level reference model.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic preload = 1'b1;
  always #5 clk = ~clk;

  // Shared host inputs
  logic        h0_req, h0_we, h1_req, h1_we;
  logic [10:0] h0_addr, h1_addr;
  logic [31:0] h0_wdata, h0_wmask, h1_wdata, h1_wmask;

  // Instance A (latency 1) outputs
  logic        a_h0_gnt, a_h1_gnt, a_h0_rv, a_h1_rv, a_ram_req, a_ram_we;
  logic [31:0] a_h0_rd, a_h1_rd, a_ram_wdata, a_ram_wmask, a_ram_rdata;
  logic [10:0] a_ram_addr;
  // Instance B (latency 3) outputs
  logic        b_h0_gnt, b_h1_gnt, b_h0_rv, b_h1_rv, b_ram_req, b_ram_we;
  logic [31:0] b_h0_rd, b_h1_rd, b_ram_wdata, b_ram_wmask, b_ram_rdata;
  logic [10:0] b_ram_addr;

  sram_arbiter #(.SramAw(11), .SramDw(32), .ReadLatency(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .h0_req_i(h0_req), .h0_gnt_o(a_h0_gnt), .h0_we_i(h0_we), .h0_addr_i(h0_addr),
    .h0_wdata_i(h0_wdata), .h0_wmask_i(h0_wmask), .h0_rvalid_o(a_h0_rv), .h0_rdata_o(a_h0_rd),
    .h1_req_i(h1_req), .h1_gnt_o(a_h1_gnt), .h1_we_i(h1_we), .h1_addr_i(h1_addr),
    .h1_wdata_i(h1_wdata), .h1_wmask_i(h1_wmask), .h1_rvalid_o(a_h1_rv), .h1_rdata_o(a_h1_rd),
    .ram_req_o(a_ram_req), .ram_we_o(a_ram_we), .ram_addr_o(a_ram_addr),
    .ram_wdata_o(a_ram_wdata), .ram_wmask_o(a_ram_wmask), .ram_rdata_i(a_ram_rdata)
  );

  sram_arbiter #(.SramAw(11), .SramDw(32), .ReadLatency(3)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .h0_req_i(h0_req), .h0_gnt_o(b_h0_gnt), .h0_we_i(h0_we), .h0_addr_i(h0_addr),
    .h0_wdata_i(h0_wdata), .h0_wmask_i(h0_wmask), .h0_rvalid_o(b_h0_rv), .h0_rdata_o(b_h0_rd),
    .h1_req_i(h1_req), .h1_gnt_o(b_h1_gnt), .h1_we_i(h1_we), .h1_addr_i(h1_addr),
    .h1_wdata_i(h1_wdata), .h1_wmask_i(h1_wmask), .h1_rvalid_o(b_h1_rv), .h1_rdata_o(b_h1_rd),
    .ram_req_o(b_ram_req), .ram_we_o(b_ram_we), .ram_addr_o(b_ram_addr),
    .ram_wdata_o(b_ram_wdata), .ram_wmask_o(b_ram_wmask), .ram_rdata_i(b_ram_rdata)
  );

  // RAM macro models: masked write; read data after 1 / 3 clocks, random junk otherwise.
  logic [31:0] mem_a [2048];
  logic [31:0] mem_b [2048];
  logic [31:0] pb0, pb1, pb2;
  assign b_ram_rdata = pb2;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 2048; i++) mem_a[i] <= '0;
      mem_a[16] <= 32'hDEADBEEF;
    end else if (a_ram_req && a_ram_we) begin
      mem_a[a_ram_addr] <= (mem_a[a_ram_addr] & ~a_ram_wmask) | (a_ram_wdata & a_ram_wmask);
    end
    a_ram_rdata <= (a_ram_req && !a_ram_we) ? mem_a[a_ram_addr] : $urandom();
  end

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 2048; i++) mem_b[i] <= '0;
      mem_b[16] <= 32'hDEADBEEF;
    end else if (b_ram_req && b_ram_we) begin
      mem_b[b_ram_addr] <= (mem_b[b_ram_addr] & ~b_ram_wmask) | (b_ram_wdata & b_ram_wmask);
    end
    pb0 <= (b_ram_req && !b_ram_we) ? mem_b[b_ram_addr] : $urandom();
    pb1 <= pb0;
    pb2 <= pb1;
  end

  // Reference model state
  logic [31:0] ref_mem [2048];
  bit          last_ref;            // 1 = host 1 granted most recently
  bit          ev_a [8], eh_a [8], ev_b [8], eh_b [8];
  logic [31:0] ed_a [8], ed_b [8];
  int unsigned cyc = 0;
  bit          granted [2];

  // Host request state (held until granted)
  bit          p_req [2];
  bit          p_we [2];
  logic [10:0] p_addr [2];
  logic [31:0] p_wd [2], p_wm [2];

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive();
    h0_req = p_req[0]; h0_we = p_we[0]; h0_addr = p_addr[0]; h0_wdata = p_wd[0]; h0_wmask = p_wm[0];
    h1_req = p_req[1]; h1_we = p_we[1]; h1_addr = p_addr[1]; h1_wdata = p_wd[1]; h1_wmask = p_wm[1];
  endtask

  task automatic set_req(input int h, input bit we, input logic [10:0] addr,
                         input logic [31:0] wd, input logic [31:0] wm);
    p_req[h] = 1'b1; p_we[h] = we; p_addr[h] = addr; p_wd[h] = wd; p_wm[h] = wm;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) begin
      ev_a[i] = 0; ev_b[i] = 0;
    end
    last_ref = 1'b1;
  endtask

  // One clock cycle: compare at the falling edge, advance the model, return
  // just after the next rising edge. Optionally assert reset after the checks.
  task automatic tick(input bit rst_after = 1'b0);
    bit          any, win, w;
    int unsigned s;
    logic [31:0] d;
    logic [65:0] exp_ret;
    @(negedge clk);
    any = p_req[0] || p_req[1];
    if (p_req[0] && p_req[1]) win = ~last_ref;
    else                      win = p_req[1];
    check("gnt_lat1", {a_h0_gnt, a_h1_gnt}, any ? (win ? 2'b01 : 2'b10) : 2'b00);
    check("gnt_lat3", {b_h0_gnt, b_h1_gnt}, any ? (win ? 2'b01 : 2'b10) : 2'b00);
    check("ram_req", a_ram_req, any);
    check("ram_fields", {a_ram_we, a_ram_addr, a_ram_wdata, a_ram_wmask},
          any ? {p_we[win], p_addr[win], p_wd[win], p_wm[win]} : 76'd0);
    s = cyc % 8;
    exp_ret = {ev_a[s] && !eh_a[s], ev_a[s] && eh_a[s],
               (ev_a[s] && !eh_a[s]) ? ed_a[s] : 32'd0, (ev_a[s] && eh_a[s]) ? ed_a[s] : 32'd0};
    check("ret_lat1", {a_h0_rv, a_h1_rv, a_h0_rd, a_h1_rd}, exp_ret);
    exp_ret = {ev_b[s] && !eh_b[s], ev_b[s] && eh_b[s],
               (ev_b[s] && !eh_b[s]) ? ed_b[s] : 32'd0, (ev_b[s] && eh_b[s]) ? ed_b[s] : 32'd0};
    check("ret_lat3", {b_h0_rv, b_h1_rv, b_h0_rd, b_h1_rd}, exp_ret);
    ev_a[s] = 0; ev_b[s] = 0;
    granted[0] = any && !win;
    granted[1] = any && win;
    if (any) begin
      last_ref = win;
      w = win;
      if (p_we[w]) begin
        ref_mem[p_addr[w]] = (ref_mem[p_addr[w]] & ~p_wm[w]) | (p_wd[w] & p_wm[w]);
      end else begin
        d = ref_mem[p_addr[w]];
        ev_a[(cyc + 1) % 8] = 1; eh_a[(cyc + 1) % 8] = w; ed_a[(cyc + 1) % 8] = d;
        ev_b[(cyc + 3) % 8] = 1; eh_b[(cyc + 3) % 8] = w; ed_b[(cyc + 3) % 8] = d;
      end
    end
    if (rst_after) begin
      #2;
      rst_n = 1'b0;
      p_req[0] = 0; p_req[1] = 0;
      drive();
      clear_model();
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Drop requests that were granted in the last tick.
  task automatic retire();
    for (int h = 0; h < 2; h++) if (granted[h]) p_req[h] = 0;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) ref_mem[i] = '0;
    ref_mem[16] = 32'hDEADBEEF;
    for (int h = 0; h < 2; h++) begin
      p_req[h] = 0; p_we[h] = 0; p_addr[h] = '0; p_wd[h] = '0; p_wm[h] = '0;
    end
    clear_model();
    drive();

    // Reset phase (RAM models load their initial contents)
    @(posedge clk); #1;
    preload = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Host 0 read of 0x010
    set_req(0, 0, 11'h010, '0, '0); drive(); tick(); retire(); drive();
    tick(); tick(); tick();

    // Host 1 masked write to 0x7FF then read back
    set_req(1, 1, 11'h7FF, 32'h12345678, 32'h0000FFFF); drive(); tick(); retire();
    set_req(1, 0, 11'h7FF, '0, '0); drive(); tick(); retire(); drive();
    tick(); tick(); tick();

    // Both hosts issue reads continuously for 8 cycles
    for (int i = 0; i < 8; i++) begin
      for (int h = 0; h < 2; h++)
        if (!p_req[h]) set_req(h, 0, 11'($urandom_range(0, 31)), '0, '0);
      drive(); tick(); retire();
    end
    drive();
    tick(); tick(); tick(); tick();

    // Host 1 alone for 3 cycles, then both: host 0 must win
    for (int i = 0; i < 3; i++) begin
      set_req(1, 0, 11'(i), '0, '0); drive(); tick(); retire();
    end
    set_req(0, 0, 11'h010, '0, '0); set_req(1, 0, 11'h003, '0, '0); drive();
    tick();
    check("h0_wins_after_h1", granted[0], 1'b1);
    retire(); drive(); tick(); retire(); drive();
    tick(); tick(); tick(); tick();

    // Read accepted, then reset before its return
    set_req(0, 0, 11'h010, '0, '0); drive();
    tick(1'b1);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick(); tick();
    set_req(0, 0, 11'h001, '0, '0); set_req(1, 0, 11'h002, '0, '0); drive();
    tick(); retire(); drive(); tick(); retire(); drive();
    tick(); tick(); tick(); tick();

    // Host 0 back-to-back reads A, B, C
    for (int i = 0; i < 3; i++) begin
      set_req(0, 0, 11'h010 + 11'(i), '0, '0); drive(); tick(); retire();
    end
    drive();
    tick(); tick(); tick(); tick();

    // Randomized traffic, requests held until granted
    for (int i = 0; i < 500; i++) begin
      for (int h = 0; h < 2; h++) begin
        if (!p_req[h] && $urandom_range(0, 9) < 6) begin
          set_req(h, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 4) == 0) ? 11'h7FF : 11'($urandom_range(0, 15)),
                  $urandom(),
                  ($urandom_range(0, 1) == 0) ? 32'hFFFFFFFF : $urandom());
        end
      end
      drive(); tick(); retire();
    end
    p_req[0] = 0; p_req[1] = 0; drive();
    tick(); tick(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-requester round-robin arbiter that shares one single-port SRAM (prim_ram_1p, 1-cycle read) between the TL-UL SRAM adapter (host 0) and a second SRAM-style master such as a boot loader or DMA (host 1).
- Owns the RAM-side rvalid generation, which prim_ram_1p does not provide.
- Routes read data back to the issuing host after the fixed read latency.
- Sits in the top level between the adapter/second master and the RAM macro.

Parameters:
- SramAw, 11, address width in words.
- SramDw, 32, data width and write-mask width.
- ReadLatency, 1, RAM cycles from accepted read to valid rdata; legal values 1..4.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- h0_req_i  input  1  host 0 request
- h0_gnt_o  output  1  host 0 grant
- h0_we_i  input  1  host 0 write enable
- h0_addr_i  input  SramAw  host 0 word address
- h0_wdata_i  input  SramDw  host 0 write data
- h0_wmask_i  input  SramDw  host 0 bit write mask
- h0_rvalid_o  output  1  host 0 read data valid
- h0_rdata_o  output  SramDw  host 0 read data
- h1_req_i, h1_gnt_o, h1_we_i, h1_addr_i, h1_wdata_i, h1_wmask_i, h1_rvalid_o, h1_rdata_o: same as host 0, for host 1
- ram_req_o  output  1  RAM request
- ram_we_o  output  1  RAM write enable
- ram_addr_o  output  SramAw  RAM address
- ram_wdata_o  output  SramDw  RAM write data
- ram_wmask_o  output  SramDw  RAM write mask
- ram_rdata_i  input  SramDw  RAM read data

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: all gnt/rvalid outputs 0; ram_req_o 0; last-grant pointer = host 1, so host 0 wins the first conflict; read-tag pipeline cleared.
- Grant timing: grant is combinational in the same cycle as req.
  - A transfer is accepted when req && gnt.
  - A host holds req and payload stable until granted.
- Arbitration:
  - Only one host requesting: that host is granted.
  - Both requesting: the host not granted most recently wins.
  - The pointer updates only on an accepted transfer, and is left unchanged in idle cycles.
  - At most one gnt high per cycle.
- RAM drive:
  - ram_req_o = h0_req_i | h1_req_i.
  - we/addr/wdata/wmask are muxed from the granted host.
  - When no host requests, the RAM fields are driven 0.
- Read tracking:
  - Shift pipeline of ReadLatency stages; each stage holds {valid, owner}.
  - An accepted read (we=0) enters as {1, granted host}; writes and idle cycles enter {0, x}.
  - The pipeline advances every cycle.
- Read return:
  - hN_rvalid_o asserts exactly ReadLatency cycles after acceptance, for one cycle, only on the owning host.
  - hN_rdata_o = ram_rdata_i when that host's rvalid is high, else 0.
- Writes: produce no rvalid.
- Throughput: back-to-back accepted reads, one per cycle, are legal; returns keep issue order and never overlap per cycle.
- Simultaneous events:
  - A new grant in the same cycle as a return to either host is legal and independent.
  - A read return to host 1 while host 0 is being granted does not affect host 0's grant.
- Reset mid-operation: in-flight reads are discarded and no rvalid follows reset deassertion.
- Fairness: under continuous requests from both hosts, grants strictly alternate; each host waits at most 1 cycle.

Decomposition:
- Shared package sram_arb_pkg:
  - typedef host_id_e (Host0=1'b0, Host1=1'b1);
  - typedef rd_tag_t packed struct {logic valid; host_id_e owner};
  - constant NumHosts=2.
- One natural sub-module, sram_arb_rdtrack: the ReadLatency-deep tag shift register with per-host rvalid decode.
- Arbitration and the mux stay in the top of the block.

Test Plan:
- Reset, then host 0 read at addr 0x010 with RAM model holding 0xDEADBEEF -> h0_gnt_o same cycle; h0_rvalid_o 1 cycle later with rdata 0xDEADBEEF; h1_rvalid_o stays 0.
- Host 1 write addr 0x7FF, data 0x12345678, mask 0x0000FFFF; then host 1 read 0x7FF -> no rvalid for the write; read returns 0x00005678 (from a zero-initialised RAM).
- Both hosts request reads every cycle for 8 cycles -> grants alternate H0,H1,H0,...; rvalids alternate 1 cycle later; 4 returns per host, in order.
- Host 0 idle and host 1 requesting for 3 cycles, then both request -> host 0 wins the conflict (pointer = host 1).
- Read accepted, then rst_ni asserted low before return, then released -> no rvalid on either host; pointer back to reset value.
- ReadLatency=3: host 0 reads A, B, C back-to-back -> rvalids in cycles +3, +4, +5, data in order; no data visible on h1_rdata_o.
